// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Issue/writeback controller for a combinational ALU. Accepts
//                instruction words over valid/ready, reads operands from an
//                internal register file, sequences the ALU and writes the
//                result back. One instruction in flight at a time.
//                Optional macro ALU_ISSUE_PERF_EN adds the perf_retired
//                counter output.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_illegal,
    input  logic [3:0]  dbg_addr,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0] perf_retired,
`endif
    output logic [31:0] dbg_data
);

    localparam int         c_IDX_W  = $clog2(NREGS);
    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_ADD = 4'h1;
    localparam logic [3:0] c_OP_OR  = 4'h4;
    localparam logic [3:0] c_OP_LI  = 4'h8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_instr;
    logic [31:0]          r_regs [NREGS];

    logic [3:0]           w_opcode;
    logic [3:0]           w_rd;
    logic [c_IDX_W-1:0]   w_rd_idx;
    logic [c_IDX_W-1:0]   w_rs1_idx;
    logic [c_IDX_W-1:0]   w_rs2_idx;
    logic [c_IDX_W-1:0]   w_dbg_idx;
    logic [31:0]          w_rs1_val;
    logic [31:0]          w_rs2_val;
    logic                 w_is_alu;
    logic                 w_is_li;
    logic                 w_is_nop;

    // Field extraction from the latched instruction; upper index bits beyond
    // the register file size are simply not looked at.
    assign w_opcode  = r_instr[31:28];
    assign w_rd      = r_instr[27:24];
    assign w_rd_idx  = r_instr[24 +: c_IDX_W];
    assign w_rs1_idx = r_instr[20 +: c_IDX_W];
    assign w_rs2_idx = r_instr[16 +: c_IDX_W];
    assign w_dbg_idx = dbg_addr[c_IDX_W-1:0];

    assign w_is_alu  = (w_opcode >= c_OP_ADD) && (w_opcode <= c_OP_OR);
    assign w_is_li   = (w_opcode == c_OP_LI);
    assign w_is_nop  = (w_opcode == c_OP_NOP);

    // Register 0 is hard-wired to zero on every read path.
    assign w_rs1_val = (w_rs1_idx == '0) ? 32'h0 : r_regs[w_rs1_idx];
    assign w_rs2_val = (w_rs2_idx == '0) ? 32'h0 : r_regs[w_rs2_idx];
    assign dbg_data  = (w_dbg_idx == '0) ? 32'h0 : r_regs[w_dbg_idx];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        w_state_next = r_state;
        instr_ready  = 1'b0;
        wb_valid     = 1'b0;
        err_illegal  = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_alu || w_is_li) begin
                    w_state_next = S_EXEC;
                end else begin
                    err_illegal  = !w_is_nop;
                    w_state_next = S_IDLE;
                end
            end
            S_EXEC: begin
                w_state_next = S_WB;
            end
            S_WB: begin
                wb_valid     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Instruction latch, ALU operand drive and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= 32'h0;
            alu_a   <= 32'h0;
            alu_b   <= 32'h0;
            alu_op  <= 4'h0;
            wb_rd   <= 4'h0;
            wb_data <= 32'h0;
        end else begin
            if ((r_state == S_IDLE) && instr_valid) begin
                r_instr <= instr;
            end
            if (r_state == S_DECODE) begin
                if (w_is_alu) begin
                    alu_a  <= w_rs1_val;
                    alu_b  <= w_rs2_val;
                    alu_op <= w_opcode;
                end else if (w_is_li) begin
                    alu_a  <= 32'h0;
                    alu_b  <= {16'h0, r_instr[15:0]};
                    alu_op <= c_OP_ADD;
                end
            end
            // alu_op is only non-zero for the single EXEC cycle.
            if (r_state == S_EXEC) begin
                alu_op  <= 4'h0;
                wb_rd   <= w_rd;
                wb_data <= alu_result;
            end
        end
    end

    // Register file write; index 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if ((r_state == S_WB) && (w_rd_idx != '0)) begin
            r_regs[w_rd_idx] <= wb_data;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    // Retired-instruction counter: writebacks plus NOPs, illegal ops excluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_retired <= 32'h0;
        end else if ((r_state == S_WB) || ((r_state == S_DECODE) && w_is_nop)) begin
            perf_retired <= perf_retired + 32'h1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Self-checking bench for alu_issue_ctrl with a behavioural
//                ALU, a register-file model and a writeback scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err_illegal;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_retired;
`endif

    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t         sb_q[$];
    wb_t         r_exp;
    logic [31:0] m_regs [16];
    int          perf_exp;
    int          errors;
    int          checks;

    alu_issue_ctrl #(.NREGS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .dbg_addr    (dbg_addr),
`ifdef ALU_ISSUE_PERF_EN
        .perf_retired(perf_retired),
`endif
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU.
    always_comb begin
        alu_result = 32'h0;
        case (alu_op)
            4'h1: alu_result = alu_a + alu_b;
            4'h2: alu_result = alu_a - alu_b;
            4'h3: alu_result = alu_a & alu_b;
            4'h4: alu_result = alu_a | alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Present one word; returns #1 after the accepting edge (DUT in DECODE).
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", {31'h0, instr_ready}, 32'h1);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_ready && n < 10);
        check("idle_timeout", {31'h0, instr_ready}, 32'h1);
    endtask

    // Model the instruction, push its expected writeback, then send it.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [15:0] imm);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            4'h1: r = m_regs[rs1] + m_regs[rs2];
            4'h2: r = m_regs[rs1] - m_regs[rs2];
            4'h3: r = m_regs[rs1] & m_regs[rs2];
            4'h4: r = m_regs[rs1] | m_regs[rs2];
            4'h8: r = {16'h0, imm};
            default: r = 32'h0;
        endcase
        if ((op >= 4'h1 && op <= 4'h4) || op == 4'h8) begin
            sb_q.push_back(wb_t'{rd: rd, data: r});
            if (rd != 4'h0) m_regs[rd] = r;
            perf_exp++;
        end else if (op == 4'h0) begin
            perf_exp++;
        end
        send(enc(op, rd, rs1, rs2, imm));
    endtask

    // Scoreboard: every writeback strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", {31'h0, wb_valid}, 32'h0);
            end else begin
                r_exp = sb_q.pop_front();
                check("wb_rd", {28'h0, wb_rd}, {28'h0, r_exp.rd});
                check("wb_data", wb_data, r_exp.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        perf_exp = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 32'h0;
        dbg_addr    = 4'h0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, instr_ready}, 32'h1);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_alu_op", {28'h0, alu_op}, 32'h0);
        check("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check("rst_wb_rd", {28'h0, wb_rd}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_err", {31'h0, err_illegal}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // LI r1,0x1234 with cycle-exact latency
        issue(4'h8, 4'h1, 4'h0, 4'h0, 16'h1234);
        check("lat_decode_wb", {31'h0, wb_valid}, 32'h0);
        check("lat_decode_ready", {31'h0, instr_ready}, 32'h0);
        check("lat_decode_op", {28'h0, alu_op}, 32'h0);
        @(posedge clk); #1;
        check("lat_exec_op", {28'h0, alu_op}, 32'h1);
        check("lat_exec_a", alu_a, 32'h0);
        check("lat_exec_b", alu_b, 32'h1234);
        check("lat_exec_wb", {31'h0, wb_valid}, 32'h0);
        @(posedge clk); #1;
        check("lat_wb_valid", {31'h0, wb_valid}, 32'h1);
        check("lat_wb_rd", {28'h0, wb_rd}, 32'h1);
        check("lat_wb_data", wb_data, 32'h00001234);
        check("lat_wb_op", {28'h0, alu_op}, 32'h0);
        @(posedge clk); #1;
        check("lat_after_wb", {31'h0, wb_valid}, 32'h0);
        check("lat_after_ready", {31'h0, instr_ready}, 32'h1);
        dbg_addr = 4'h1; #1;
        check("dbg_r1", dbg_data, 32'h00001234);

        // SUB with wrap-around, dependent on the two preceding LIs
        issue(4'h8, 4'h1, 4'h0, 4'h0, 16'h0005); wait_idle();
        issue(4'h8, 4'h2, 4'h0, 4'h0, 16'h0007); wait_idle();
        issue(4'h2, 4'h3, 4'h1, 4'h2, 16'h0000);
        @(posedge clk); #1;
        check("sub_exec_op", {28'h0, alu_op}, 32'h2);
        check("sub_exec_a", alu_a, 32'h5);
        check("sub_exec_b", alu_b, 32'h7);
        wait_idle();
        dbg_addr = 4'h3; #1;
        check("dbg_r3", dbg_data, 32'hFFFFFFFE);

        // AND / OR
        issue(4'h8, 4'h1, 4'h0, 4'h0, 16'hFF0F); wait_idle();
        issue(4'h8, 4'h2, 4'h0, 4'h0, 16'h0FF0); wait_idle();
        issue(4'h3, 4'h4, 4'h1, 4'h2, 16'h0000); wait_idle();
        issue(4'h4, 4'h5, 4'h1, 4'h2, 16'h0000); wait_idle();
        dbg_addr = 4'h4; #1;
        check("dbg_r4", dbg_data, 32'h00000F00);
        dbg_addr = 4'h5; #1;
        check("dbg_r5", dbg_data, 32'h0000FFFF);

        // Illegal opcode: one-cycle error, no writeback, registers unchanged
        send(enc(4'hA, 4'h6, 4'h1, 4'h2, 16'hBEEF));
        check("ill_err", {31'h0, err_illegal}, 32'h1);
        check("ill_wb", {31'h0, wb_valid}, 32'h0);
        @(posedge clk); #1;
        check("ill_err_clear", {31'h0, err_illegal}, 32'h0);
        check("ill_ready", {31'h0, instr_ready}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = i[3:0]; #1;
            check($sformatf("ill_r%0d", i), dbg_data, m_regs[i]);
        end

        // NOP: ready again two cycles after the handshake
        issue(4'h0, 4'h7, 4'h0, 4'h0, 16'h0000);
        check("nop_busy", {31'h0, instr_ready}, 32'h0);
        check("nop_err", {31'h0, err_illegal}, 32'h0);
        @(posedge clk); #1;
        check("nop_ready", {31'h0, instr_ready}, 32'h1);
        check("nop_wb", {31'h0, wb_valid}, 32'h0);

        // LI r0: strobe fires, register 0 stays zero
        issue(4'h8, 4'h0, 4'h0, 4'h0, 16'h0055); wait_idle();
        dbg_addr = 4'h0; #1;
        check("dbg_r0", dbg_data, 32'h0);
`ifdef ALU_ISSUE_PERF_EN
        check("perf_count", perf_retired, perf_exp);
`endif

        // Reset during EXEC of ADD r6,r3,r5
        send(enc(4'h1, 4'h6, 4'h3, 4'h5, 16'h0000));
        @(posedge clk); #1;
        check("rmid_exec_op", {28'h0, alu_op}, 32'h1);
        check("rmid_exec_a", alu_a, m_regs[3]);
        rst_n = 1'b0; #1;
        check("rmid_ready", {31'h0, instr_ready}, 32'h1);
        check("rmid_op", {28'h0, alu_op}, 32'h0);
        check("rmid_wb", {31'h0, wb_valid}, 32'h0);
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        perf_exp = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rmid_no_wb", {31'h0, wb_valid}, 32'h0);
        end
        check("rmid_ready_after", {31'h0, instr_ready}, 32'h1);
        dbg_addr = 4'h6; #1;
        check("rmid_r6", dbg_data, 32'h0);
        dbg_addr = 4'h5; #1;
        check("rmid_r5", dbg_data, 32'h0);
`ifdef ALU_ISSUE_PERF_EN
        check("rmid_perf", perf_retired, 32'h0);
`endif

        // Operation resumes normally after reset
        issue(4'h8, 4'h7, 4'h0, 4'h0, 16'hABCD); wait_idle();
        dbg_addr = 4'h7; #1;
        check("post_r7", dbg_data, 32'h0000ABCD);
        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
